fpdiv: RTL

Iterative IEEE-754 single-precision (parameterisable) floating-point divider computing a / b with round-to-nearest-even. It pairs with the pipelined `fpmul` unit in the FP execute cluster and shares its `valid`/`done` operand handshake and exception-flag ordering, extended with a divide-by-zero bit. The block is multi-cycle: a radix-2 restoring mantissa divider behind a small FSM, accepting one operation at a time.

---
 rtl/fpdiv_if.sv | 16 +
 rtl/fpdiv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_if.sv
// Operand/result handshake bundle shared between the fpdiv unit and its requester.
// The requester drives valid/a/b; the divider returns busy/result/fex/done.
interface fpdiv_if #(
  parameter int DWIDTH = 32
);
  logic              valid;
  logic [DWIDTH-1:0] a;
  logic [DWIDTH-1:0] b;
  logic              busy;
  logic [DWIDTH-1:0] result;
  logic [3:0]        fex;
  logic              done;

  modport master (output valid, a, b, input busy, result, fex, done);
  modport slave  (input valid, a, b, output busy, result, fex, done);
endinterface

// File: rtl/fpdiv.sv
// Iterative IEEE-754 divider: one radix-2 restoring quotient bit per cycle, RNE rounding.
// fex = {divide-by-zero, overflow, underflow, inexact}.
module fpdiv #(
  parameter int DWIDTH = 32,
  parameter int EWIDTH = 8,
  parameter int MWIDTH = 23
) (
  input logic    clk,
  input logic    rst_n,
  fpdiv_if.slave bus
);
  localparam int SW = MWIDTH + 1;
  localparam int QW = MWIDTH + 3;
  localparam int RW = MWIDTH + 2;
  localparam int XW = EWIDTH + 2;
  localparam int LW = $clog2(SW + 1);
  localparam int CW = $clog2(QW + 1);
  localparam logic signed [XW-1:0] BIAS      = XW'((2 ** (EWIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] MAX_EXP   = XW'((2 ** EWIDTH) - 1);
  localparam logic signed [XW-1:0] MIN_SUB   = XW'(-MWIDTH);
  localparam logic [CW-1:0]        LAST_ITER = CW'(QW - 1);
  localparam logic [DWIDTH-1:0]    QNAN      = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(MWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, ROUND} state_t;

  state_t               state_q, state_d;
  logic [DWIDTH-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]           fex_q, fex_d;
  logic                 done_q, done_d, sign_q, sign_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [SW-1:0]        mb_q, mb_d;
  logic [QW-1:0]        quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  function automatic logic [LW-1:0] lzc(input logic [SW-1:0] sig);
    logic [LW-1:0] n;
    n = LW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sig[i]) n = LW'(SW - 1 - i);
    end
    return n;
  endfunction

  logic                 sa, sb;
  logic [EWIDTH-1:0]    ea, eb;
  logic [MWIDTH-1:0]    fa, fb;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
  logic [SW-1:0]        sig_a, sig_b, ma_n, mb_n;
  logic [LW-1:0]        lz_a, lz_b;
  logic signed [XW-1:0] xa, xb, e_un;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea) & ~(|fa);
  assign b_zero = ~(|eb) & ~(|fb);
  assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Subnormals are normalised up front so the divider always sees 1.xxx significands.
  assign sig_a = {|ea, fa};
  assign sig_b = {|eb, fb};
  assign lz_a  = lzc(sig_a);
  assign lz_b  = lzc(sig_b);
  assign ma_n  = sig_a << lz_a;
  assign mb_n  = sig_b << lz_b;
  assign xa    = (|ea) ? XW'(ea) : XW'(1) - XW'(lz_a);
  assign xb    = (|eb) ? XW'(eb) : XW'(1) - XW'(lz_b);
  assign e_un  = xa - xb + BIAS;

  logic                 tiny, sticky, g_bit, r_bit, inexact, round_up;
  logic [XW-1:0]        shamt;
  logic [QW-1:0]        quo_s;
  logic [SW-1:0]        mant;
  logic [SW:0]          sum;
  logic signed [XW-1:0] exp_r;

  // Tiny results are denormalised before rounding; shifted-out bits fold into sticky.
  always_comb begin
    tiny   = exp_q[XW-1] | (exp_q == '0);
    shamt  = XW'(1) - exp_q;
    quo_s  = quo_q;
    sticky = |rem_q;
    if (tiny) begin
      quo_s  = quo_q >> shamt;
      sticky = sticky | (|(quo_q & ~({QW{1'b1}} << shamt)));
    end
    mant     = quo_s[QW-1:2];
    g_bit    = quo_s[1];
    r_bit    = quo_s[0];
    inexact  = g_bit | r_bit | sticky;
    round_up = g_bit & (r_bit | sticky | mant[0]);
    sum      = {1'b0, mant} + {{SW{1'b0}}, round_up};
    exp_r    = sum[SW] ? exp_q + XW'(1) : exp_q;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    fex_d    = fex_q;
    done_d   = 1'b0;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    mb_d     = mb_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        if (is_special) begin
          state_d = IDLE;
          done_d  = 1'b1;
          fex_d   = 4'b0000;
          if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            result_d = QNAN;
          end else if (a_inf) begin
            result_d = {sa ^ sb, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
          end else if (b_inf) begin
            result_d = {sa ^ sb, {(DWIDTH-1){1'b0}}};
          end else if (b_zero) begin
            result_d = {sa ^ sb, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
            fex_d    = 4'b1000;
          end else begin
            result_d = {sa ^ sb, {(DWIDTH-1){1'b0}}};
          end
        end else begin
          state_d = DIVIDE;
          sign_d  = sa ^ sb;
          mb_d    = mb_n;
          quo_d   = '0;
          cnt_d   = '0;
          // Pre-scaling keeps the quotient in [1,2), so its MSB is always the integer bit.
          if (ma_n < mb_n) begin
            rem_d = {ma_n, 1'b0};
            exp_d = e_un - XW'(1);
          end else begin
            rem_d = {1'b0, ma_n};
            exp_d = e_un;
          end
        end
      end
      DIVIDE: begin
        if (rem_q >= {1'b0, mb_q}) begin
          rem_d = (rem_q - {1'b0, mb_q}) << 1;
          quo_d = {quo_q[QW-2:0], 1'b1};
        end else begin
          rem_d = rem_q << 1;
          quo_d = {quo_q[QW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = ROUND;
      end
      ROUND: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (exp_q >= MAX_EXP) begin
          result_d = {sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
          fex_d    = 4'b0101;
        end else if (tiny && (exp_q < MIN_SUB)) begin
          result_d = {sign_q, {(DWIDTH-1){1'b0}}};
          fex_d    = 4'b0011;
        end else if (tiny) begin
          result_d = {sign_q, {(EWIDTH-1){1'b0}}, sum[MWIDTH], sum[MWIDTH-1:0]};
          fex_d    = {2'b00, inexact, inexact};
        end else if (exp_r >= MAX_EXP) begin
          result_d = {sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
          fex_d    = 4'b0101;
        end else begin
          result_d = {sign_q, exp_r[EWIDTH-1:0], sum[SW] ? sum[MWIDTH:1] : sum[MWIDTH-1:0]};
          fex_d    = {3'b000, inexact};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      fex_q    <= '0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      mb_q     <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      fex_q    <= fex_d;
      done_q   <= done_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      mb_q     <= mb_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.result = result_q;
  assign bus.fex    = fex_q;
  assign bus.done   = done_q;
endmodule
